// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the memory-stage load/store unit and its helpers:
//   - state_t   : access FSM states (IDLE, REQ, WAIT_R, DONE)
//   - F3_*      : funct3 size/sign encodings for loads and stores
//   - RESULT_MEM: ResultSrcM encoding that marks a load
//   - helpers   : access size decode, store lane strobes/data, misalign test
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [1:0] RESULT_MEM = 2'b01;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Stores only know SB/SH; every other store encoding is a full word.
    // Loads additionally treat the unsigned byte/half encodings as byte/half.
    function automatic size_t access_size(input logic [2:0] f3, input logic is_store);
        size_t sz;
        sz = SZ_W;
        if (is_store) begin
            case (f3)
                F3_B:    sz = SZ_B;
                F3_H:    sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end else begin
            case (f3)
                F3_B, F3_BU: sz = SZ_B;
                F3_H, F3_HU: sz = SZ_H;
                default:     sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

    // Byte enables; a misaligned half at offset 3 loses its upper byte.
    function automatic logic [3:0] store_strb(input size_t sz, input logic [1:0] off);
        logic [3:0] strb;
        case (sz)
            SZ_B:    strb = 4'b0001 << off;
            SZ_H:    strb = 4'b0011 << off;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replicate the LSB-justified store data into every lane so the strobes
    // alone pick the destination bytes.
    function automatic logic [31:0] store_data(input size_t sz, input logic [31:0] data);
        logic [31:0] d;
        case (sz)
            SZ_B:    d = {4{data[7:0]}};
            SZ_H:    d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
        return ((sz == SZ_H) && off[0]) || ((sz == SZ_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Valid/ready data-memory bus between the load/store unit (master) and the
// data memory or its responder (slave).
//   bus_valid  master->slave  request valid, held with stable fields until ready
//   bus_ready  slave->master  request accepted
//   bus_we     master->slave  1 = write
//   bus_addr   master->slave  word-aligned byte address
//   bus_wdata  master->slave  lane-replicated store data
//   bus_wstrb  master->slave  byte enables
//   bus_rvalid slave->master  read data valid
//   bus_rdata  slave->master  read data word
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int XLEN = 32
);
    logic                bus_valid;
    logic                bus_ready;
    logic                bus_we;
    logic [XLEN-1:0]     bus_addr;
    logic [XLEN-1:0]     bus_wdata;
    logic [XLEN/8-1:0]   bus_wstrb;
    logic                bus_rvalid;
    logic [XLEN-1:0]     bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load-data alignment and extension. Selects the byte or half
// at byte offset `off` of the read word and sign/zero-extends it by funct3.
//   rdata  in  32  raw read word
//   off    in  2   byte offset within the word
//   funct3 in  3   LB/LH/LW/LBU/LHU (others = whole word)
//   data   out 32  extended load value
// -----------------------------------------------------------------------------
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        sel_b = lane[off];
        // The upper byte index wraps within the word for a half at offset 3.
        sel_h = {lane[off + 2'd1], lane[off]};
        case (funct3)
            F3_B:    data = {{24{sel_b[7]}}, sel_b};
            F3_BU:   data = {24'h000000, sel_b};
            F3_H:    data = {{16{sel_h[15]}}, sel_h};
            F3_HU:   data = {16'h0000, sel_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage load/store unit. Turns the M-stage controls into one request on
// a valid/ready data bus, stalls the pipeline until the access completes, and
// returns the extended load value in the DONE cycle.
//   clk, rst    clock and synchronous active-high reset
//   MemWriteM   store request (wins over a simultaneous load)
//   ResultSrcM  load request when equal to RESULT_MEM
//   funct3M     access size/sign
//   ALUResultM  byte address
//   WriteDataM  LSB-justified store data
//   StallM      freeze IF..M while an access is outstanding
//   ReadDataM   extended load data, valid while in DONE
//   bus         mem_access_unit_if master port
//   MisalignM   misaligned-access trap pulse (DONE cycle)
// Optional feature macro MISALIGN_TRAP_EN: misaligned half/word accesses skip
// the bus and finish with MisalignM=1; when undefined MisalignM is tied low.
// -----------------------------------------------------------------------------
module mem_access_unit
    import riscv_pkg::*;
#(
    parameter int         XLEN       = 32,
    parameter logic [1:0] RESULT_MEM = riscv_pkg::RESULT_MEM
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MemWriteM,
    input  logic [1:0]          ResultSrcM,
    input  logic [2:0]          funct3M,
    input  logic [XLEN-1:0]     ALUResultM,
    input  logic [XLEN-1:0]     WriteDataM,
    output logic                StallM,
    output logic [XLEN-1:0]     ReadDataM,
    mem_access_unit_if.master   bus,
    output logic                MisalignM
);

    state_t              state_reg;
    logic                valid_reg;
    logic                we_reg;
    logic [XLEN-1:0]     addr_reg;
    logic [XLEN-1:0]     wdata_reg;
    logic [XLEN/8-1:0]   wstrb_reg;
    logic [XLEN-1:0]     read_data_reg;
    logic [2:0]          f3_reg;
    logic [1:0]          off_reg;

    logic                access;
    logic [1:0]          off_in;
    size_t               size_in;
    logic                trap_in;
    logic [XLEN-1:0]     load_data;

    assign access  = MemWriteM | (ResultSrcM == RESULT_MEM);
    assign off_in  = ALUResultM[1:0];
    assign size_in = access_size(funct3M, MemWriteM);

    // Combinational so the pipeline freezes in the very cycle the access
    // shows up in IDLE; released in DONE so the next access follows directly.
    assign StallM = access & (state_reg != DONE);

`ifdef MISALIGN_TRAP_EN
    logic misalign_reg;
    assign trap_in   = is_misaligned(size_in, off_in);
    assign MisalignM = misalign_reg;
`else
    assign trap_in   = 1'b0;
    assign MisalignM = 1'b0;
`endif

    load_extend u_load_extend (
        .rdata  (bus.bus_rdata),
        .off    (off_reg),
        .funct3 (f3_reg),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            valid_reg     <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            read_data_reg <= '0;
            f3_reg        <= 3'b000;
            off_reg       <= 2'b00;
`ifdef MISALIGN_TRAP_EN
            misalign_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        f3_reg        <= funct3M;
                        off_reg       <= off_in;
                        read_data_reg <= '0;
                        if (trap_in) begin
                            state_reg    <= DONE;
`ifdef MISALIGN_TRAP_EN
                            misalign_reg <= 1'b1;
`endif
                        end else begin
                            state_reg <= REQ;
                            valid_reg <= 1'b1;
                            we_reg    <= MemWriteM;
                            addr_reg  <= {ALUResultM[XLEN-1:2], 2'b00};
                            wdata_reg <= store_data(size_in, WriteDataM);
                            // Loads never enable write lanes.
                            wstrb_reg <= MemWriteM ? store_strb(size_in, off_in) : 4'b0000;
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_ready) begin
                        valid_reg <= 1'b0;
                        if (we_reg) begin
                            state_reg <= DONE;
                        end else if (bus.bus_rvalid) begin
                            // Responder returned data in the accept cycle.
                            read_data_reg <= load_data;
                            state_reg     <= DONE;
                        end else begin
                            state_reg <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (bus.bus_rvalid) begin
                        read_data_reg <= load_data;
                        state_reg     <= DONE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
`ifdef MISALIGN_TRAP_EN
                    misalign_reg <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign bus.bus_valid = valid_reg;
    assign bus.bus_we    = we_reg;
    assign bus.bus_addr  = addr_reg;
    assign bus.bus_wdata = wdata_reg;
    assign bus.bus_wstrb = wstrb_reg;
    assign ReadDataM     = read_data_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Scoreboard bench for mem_access_unit: the stimulus process pushes expected
// bus requests and completions into queues, a bus responder plays the memory
// side with per-transaction delays, and a monitor compares whatever the DUT
// presents. Honours MISALIGN_TRAP_EN when defined.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MisalignM;

    always #5 clk = ~clk;

    mem_access_unit_if #(.XLEN(32)) mem ();

    mem_access_unit #(.XLEN(32), .RESULT_MEM(2'b01)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .bus        (mem),
        .MisalignM  (MisalignM)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic        is_load;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rd;
        logic        trap;
        int          stall;
    } done_t;

    typedef struct {
        int          rdly;
        int          rvdly;
        logic [31:0] rdata;
    } resp_t;

    req_t  req_q[$];
    done_t done_q[$];
    resp_t resp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] exp_strb(input int n, input int off);
        if (n == 4) return 4'hF;
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] exp_wdata(input int n, input logic [31:0] wd);
        logic [31:0] b;
        logic [31:0] h;
        b = {24'h0, wd[7:0]};
        h = {16'h0, wd[15:0]};
        if (n == 1) return b * 32'h01010101;
        if (n == 2) return h * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int off, input logic [31:0] rdata);
        int n;
        longint unsigned w;
        longint unsigned span;
        longint unsigned v;
        n = size_bytes(1'b0, f3);
        if (n == 4) return rdata;
        w    = rdata;
        span = 64'd1 << (8 * n);
        v    = (w >> (8 * off)) % span;
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= span / 2) return 32'(v - span);
        return 32'(v);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int k);
        logic [1:0] r;
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            r = 2'($urandom_range(0, 2));
            if (r == 2'b01) r = 2'b11;
            MemWriteM  = 1'b0;
            ResultSrcM = r;
            ALUResultM = $urandom;
            WriteDataM = $urandom;
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] rsrc, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int rdly, input int rvdly, input logic [31:0] rdata);
        int    n;
        int    off;
        int    c;
        logic  trap;
        req_t  r;
        done_t d;
        resp_t s;
        n    = size_bytes(we, f3);
        off  = int'(addr[1:0]);
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = (n == 2 && (off % 2) == 1) || (n == 4 && off != 0);
`endif
        @(posedge clk); #1;
        if (!trap) begin
            r.we    = we;
            r.addr  = addr - 32'(off);
            r.wdata = exp_wdata(n, wd);
            r.wstrb = exp_strb(n, off);
            req_q.push_back(r);
            s.rdly  = rdly;
            s.rvdly = rvdly;
            s.rdata = rdata;
            resp_q.push_back(s);
        end
        d.is_load = !we;
        d.f3      = f3;
        d.addr    = addr;
        d.rd      = trap ? 32'h0 : exp_load(f3, off, rdata);
        d.trap    = trap;
        d.stall   = trap ? 1 : (2 + rdly + (we ? 0 : rvdly));
        done_q.push_back(d);
        MemWriteM  = we;
        ResultSrcM = rsrc;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (StallM && c < 64);
        chk("access_completes", 32'(StallM), 32'd0);
    endtask

    // ---------------- bus responder ----------------
    initial begin : responder
        int    cnt;
        int    rcnt;
        logic  active;
        logic  rpend;
        resp_t cur;
        cnt    = 0;
        rcnt   = 0;
        active = 1'b0;
        rpend  = 1'b0;
        cur.rdly  = 0;
        cur.rvdly = 0;
        cur.rdata = 32'h0;
        mem.bus_ready  = 1'b0;
        mem.bus_rvalid = 1'b0;
        mem.bus_rdata  = 32'h0;
        forever begin
            @(posedge clk); #1;
            mem.bus_ready  = 1'b0;
            mem.bus_rvalid = 1'b0;
            mem.bus_rdata  = $urandom;
            if (rpend) begin
                if (rcnt == 0) begin
                    mem.bus_rvalid = 1'b1;
                    mem.bus_rdata  = cur.rdata;
                    rpend          = 1'b0;
                end else begin
                    rcnt--;
                end
            end else if (mem.bus_valid && !rst) begin
                if (!active) begin
                    if (resp_q.size() > 0) begin
                        cur = resp_q.pop_front();
                    end else begin
                        cur.rdly  = 0;
                        cur.rvdly = 0;
                        cur.rdata = 32'h0;
                    end
                    active = 1'b1;
                    cnt    = cur.rdly;
                end
                if (cnt == 0) begin
                    mem.bus_ready = 1'b1;
                    active        = 1'b0;
                    if (!mem.bus_we) begin
                        if (cur.rvdly == 0) begin
                            mem.bus_rvalid = 1'b1;
                            mem.bus_rdata  = cur.rdata;
                        end else begin
                            rpend = 1'b1;
                            rcnt  = cur.rvdly - 1;
                        end
                    end
                end else begin
                    cnt--;
                end
            end else if (!mem.bus_valid && $urandom_range(0, 7) == 0) begin
                // Spurious rvalid while nothing is outstanding.
                mem.bus_rvalid = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int    stall_cnt;
        logic  held;
        logic  access;
        req_t  prev;
        req_t  e;
        done_t d;
        stall_cnt = 0;
        held      = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_cnt = 0;
                held      = 1'b0;
            end else begin
                if (mem.bus_valid) begin
                    if (held) begin
                        chk("hold_addr",  mem.bus_addr,  prev.addr);
                        chk("hold_we",    32'(mem.bus_we), 32'(prev.we));
                        chk("hold_wdata", mem.bus_wdata, prev.wdata);
                        chk("hold_wstrb", 32'(mem.bus_wstrb), 32'(prev.wstrb));
                    end
                    prev.addr  = mem.bus_addr;
                    prev.we    = mem.bus_we;
                    prev.wdata = mem.bus_wdata;
                    prev.wstrb = mem.bus_wstrb;
                    if (mem.bus_ready) begin
                        held = 1'b0;
                        if (req_q.size() == 0) begin
                            chk("unexpected_request", 32'(mem.bus_valid), 32'd0);
                        end else begin
                            e = req_q.pop_front();
                            chk("req_we",   32'(mem.bus_we), 32'(e.we));
                            chk("req_addr", mem.bus_addr, e.addr);
                            if (e.we) begin
                                chk("req_wdata", mem.bus_wdata, e.wdata);
                                chk("req_wstrb", 32'(mem.bus_wstrb), 32'(e.wstrb));
                            end
                        end
                    end else begin
                        held = 1'b1;
                    end
                end else begin
                    held = 1'b0;
                end

                access = MemWriteM | (ResultSrcM == 2'b01);
                if (access && !StallM) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 32'(StallM), 32'd1);
                    end else begin
                        d = done_q.pop_front();
                        chk("stall_cycles", 32'(stall_cnt), 32'(d.stall));
                        chk("misalign_flag", 32'(MisalignM), 32'(d.trap));
                        if (d.is_load || d.trap) chk("read_data", ReadDataM, d.rd);
                        $display("txn %s f3=%0d addr=0x%08h stall=%0d rdata=0x%08h misalign=%0b",
                                 d.is_load ? "load " : "store", d.f3, d.addr, stall_cnt,
                                 ReadDataM, MisalignM);
                    end
                    stall_cnt = 0;
                end else begin
                    chk("misalign_low", 32'(MisalignM), 32'd0);
                    stall_cnt = (access && StallM) ? stall_cnt + 1 : 0;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #1000000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin : stim
        req_t r;
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        funct3M    = 3'b000;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid",    32'(mem.bus_valid), 32'd0);
        chk("reset_we",       32'(mem.bus_we), 32'd0);
        chk("reset_addr",     mem.bus_addr, 32'h0);
        chk("reset_wdata",    mem.bus_wdata, 32'h0);
        chk("reset_wstrb",    32'(mem.bus_wstrb), 32'd0);
        chk("reset_readdata", ReadDataM, 32'h0);
        chk("reset_misalign", 32'(MisalignM), 32'd0);
        chk("reset_stall",    32'(StallM), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases
        issue(1'b1, 2'b00, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0);
        issue(1'b1, 2'b00, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0);
        issue(1'b0, 2'b01, 3'b000, 32'h0000_0102, 32'h0, 0, 2, 32'h0080_0000);
        issue(1'b0, 2'b01, 3'b100, 32'h0000_0102, 32'h0, 0, 2, 32'h0080_0000);
        issue(1'b0, 2'b01, 3'b001, 32'h0000_0100, 32'h0, 3, 1, 32'h1234_F00D);
        issue(1'b0, 2'b01, 3'b010, 32'h0000_0108, 32'h0, 0, 0, 32'h7654_3210);
        issue(1'b1, 2'b01, 3'b001, 32'h0000_0042, 32'h1357_2468, 1, 0, 32'h0);
        issue(1'b0, 2'b01, 3'b010, 32'h0000_0104, 32'h0, 0, 1, 32'h89AB_CDEF);

        // Reset while waiting for read data; a stale rvalid follows.
        @(posedge clk); #1;
        r.we = 1'b0; r.addr = 32'h0000_0200; r.wdata = 32'h0; r.wstrb = 4'h0;
        req_q.push_back(r);
        resp_q.push_back('{rdly: 0, rvdly: 3, rdata: 32'hCAFE_F00D});
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b01;
        funct3M    = 3'b010;
        ALUResultM = 32'h0000_0200;
        @(posedge clk);
        @(posedge clk); #1;
        rst        = 1'b1;
        ResultSrcM = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("after_reset_valid",    32'(mem.bus_valid), 32'd0);
            chk("after_reset_readdata", ReadDataM, 32'h0);
            chk("after_reset_addr",     mem.bus_addr, 32'h0);
            chk("after_reset_stall",    32'(StallM), 32'd0);
        end

`ifdef MISALIGN_TRAP_EN
        issue(1'b0, 2'b01, 3'b010, 32'h0000_0101, 32'h0, 0, 0, 32'h1111_2222);
        issue(1'b1, 2'b00, 3'b001, 32'h0000_0203, 32'hABCD, 0, 0, 32'h0);
        issue(1'b0, 2'b01, 3'b101, 32'h0000_0102, 32'h0, 0, 1, 32'hBEEF_8001);
`endif

        // Randomised traffic
        for (int t = 0; t < 150; t++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [1:0]  rs;
            int          n;
            we = 1'($urandom_range(0, 1));
            if (we) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'd0;
                    1:       f3 = 3'd1;
                    2:       f3 = 3'd2;
                    3:       f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(6, 7));
            a = $urandom;
            n = size_bytes(we, f3);
            if (n == 2) a[0] = 1'b0;
            if (n == 4) a[1:0] = 2'b00;
`ifdef MISALIGN_TRAP_EN
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
`endif
            rs = we ? 2'($urandom_range(0, 3)) : 2'b01;
            issue(we, rs, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        idle(6);
        chk("req_queue_drained",  32'(req_q.size()), 32'd0);
        chk("done_queue_drained", 32'(done_q.size()), 32'd0);
        chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
